// File: rtl/mc_main_ctrl_fsm_if.sv
// Control bundle between the multi-cycle CPU main control FSM and its datapath.
// The FSM drives the master side and the datapath drives the slave side.
interface mc_main_ctrl_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
    logic       mem_err;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, pc_source,
               i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, illegal_op, mem_err
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, pc_source,
               i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, illegal_op, mem_err
    );
endinterface

// File: rtl/mc_main_ctrl_fsm.sv
// Main control FSM of the multi-cycle CPU: sequences FETCH/DECODE/EXEC/MEM/WB,
// stalls on the memory ready handshake and aborts a stalled access after MEM_TIMEOUT cycles.
module mc_main_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    mc_main_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_SHIFT,
        S_EXEC_I,
        S_ALU_WB,
        S_IMM_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_MEM_WB,
        S_BRANCH,
        S_JUMP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;

    // Abort fires on the wait cycle that would bring the count up to MEM_TIMEOUT.
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_q, illegal_d;
    logic       mem_err_q, mem_err_d;

    logic       in_wait;
    logic       timeout;
    logic       enter_wait;

    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // A ready in the final wait cycle completes the access instead of aborting it.
    assign timeout = in_wait && !bus.mem_ready && (wait_cnt_q == WAIT_LIMIT);

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        mem_err_d = 1'b0;

        case (state_q)
            S_IDLE:       state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (bus.funct inside {FN_SLL, FN_SRL, FN_SRA}) begin
                            state_d = S_EXEC_SHIFT;
                        end else begin
                            state_d = S_EXEC_R;
                        end
                    end
                    OP_LW,
                    OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    OP_ADDI:  state_d = S_EXEC_I;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R,
            S_EXEC_SHIFT: state_d = S_ALU_WB;
            S_EXEC_I:     state_d = S_IMM_WB;
            S_MEM_ADDR:   state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_ALU_WB,
            S_IMM_WB,
            S_MEM_WB,
            S_BRANCH,
            S_JUMP:       state_d = S_FETCH;
            default:      state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d   = S_FETCH;
            mem_err_d = 1'b1;
        end
    end

    // FETCH re-entered after an abort must also start its wait budget from zero.
    assign enter_wait = ((state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR))
                        && ((state_d != state_q) || timeout);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (enter_wait) begin
            wait_cnt_d = '0;
        end else if (in_wait && !bus.mem_ready) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                // IR and PC+4 commit only in the cycle memory delivers the word.
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b11;
            end
            S_EXEC_R: begin
                alu_op    = 2'b10;
            end
            S_EXEC_SHIFT: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXEC_I,
            S_MEM_ADDR: begin
                alu_src_b = 2'b10;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_IMM_WB: begin
                reg_write = 1'b1;
            end
            S_MEM_RD: begin
                mem_read  = 1'b1;
                i_or_d    = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: begin
            end
        endcase
    end

    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.pc_source     = pc_source;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.reg_write     = reg_write;
    assign bus.reg_dst       = reg_dst;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.illegal_op    = illegal_q;
    assign bus.mem_err       = mem_err_q;

endmodule

// File: tb/tb_mc_main_ctrl_fsm.sv
// Directed bench for mc_main_ctrl_fsm: per-cycle expected control words go through a scoreboard queue.
module tb_mc_main_ctrl_fsm;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcs;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       ill;
        logic       merr;
    } ctl_t;

    localparam logic [5:0] R_T  = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;
    localparam logic [5:0] SLL  = 6'b000000;
    localparam logic [5:0] ADD  = 6'b100000;

    logic  clk = 1'b0;
    logic  rst_n;
    int    total = 0;
    int    bad = 0;
    ctl_t  exp_q[$];
    string tag_q[$];

    mc_main_ctrl_fsm_if bus();

    mc_main_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic ctl_t c_zero();
        ctl_t c = '0;
        return c;
    endfunction

    function automatic ctl_t c_fetch(input logic rdy, input logic ill, input logic merr);
        ctl_t c = '0;
        c.mr = 1'b1; c.a = 2'b01; c.b = 2'b01;
        c.irw = rdy; c.pcw = rdy; c.ill = ill; c.merr = merr;
        return c;
    endfunction

    function automatic ctl_t c_decode();
        ctl_t c = '0;
        c.a = 2'b01; c.b = 2'b11;
        return c;
    endfunction

    function automatic ctl_t c_exec_r();
        ctl_t c = '0;
        c.op = 2'b10;
        return c;
    endfunction

    function automatic ctl_t c_shift();
        ctl_t c = '0;
        c.a = 2'b10; c.op = 2'b10;
        return c;
    endfunction

    function automatic ctl_t c_imm_alu();
        ctl_t c = '0;
        c.b = 2'b10;
        return c;
    endfunction

    function automatic ctl_t c_wb(input logic rd, input logic m2r);
        ctl_t c = '0;
        c.rw = 1'b1; c.rd = rd; c.m2r = m2r;
        return c;
    endfunction

    function automatic ctl_t c_mem(input logic wr);
        ctl_t c = '0;
        c.iord = 1'b1; c.mr = !wr; c.mw = wr;
        return c;
    endfunction

    function automatic ctl_t c_branch();
        ctl_t c = '0;
        c.op = 2'b01; c.pcwc = 1'b1; c.pcs = 2'b01;
        return c;
    endfunction

    function automatic ctl_t c_jump();
        ctl_t c = '0;
        c.pcw = 1'b1; c.pcs = 2'b10;
        return c;
    endfunction

    function automatic ctl_t observe();
        ctl_t c;
        c.a = bus.alu_src_a;   c.b = bus.alu_src_b;       c.op = bus.alu_op;
        c.pcw = bus.pc_write;  c.pcwc = bus.pc_write_cond; c.pcs = bus.pc_source;
        c.iord = bus.i_or_d;   c.mr = bus.mem_read;       c.mw = bus.mem_write;
        c.irw = bus.ir_write;  c.rw = bus.reg_write;      c.rd = bus.reg_dst;
        c.m2r = bus.mem_to_reg; c.ill = bus.illegal_op;   c.merr = bus.mem_err;
        return c;
    endfunction

    task automatic push_exp(input ctl_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic chk();
        ctl_t  e;
        ctl_t  got;
        string t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = observe();
        total++;
        assert (got === e) else begin
            bad++;
            $error("FAIL %s got=%05h exp=%05h", t, got, e);
        end
    endtask

    task automatic drv(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                       input logic rdy, input ctl_t e, input string tag);
        @(negedge clk);
        bus.opcode    = opc;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = rdy;
        push_exp(e, tag);
        #1;
        chk();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        repeat (3) drv(R_T, SLL, 1'b0, 1'b1, c_zero(), "reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(c_zero(), "idle_after_reset");
        #1;
        chk();

        // sll, with one stalled fetch cycle
        drv(R_T, SLL, 1'b0, 1'b0, c_fetch(1'b0, 1'b0, 1'b0), "fetch_wait");
        drv(R_T, SLL, 1'b0, 1'b1, c_fetch(1'b1, 1'b0, 1'b0), "fetch_sll");
        drv(R_T, SLL, 1'b0, 1'b0, c_decode(),                "decode_sll");
        drv(R_T, SLL, 1'b0, 1'b1, c_shift(),                 "exec_shift");
        drv(R_T, SLL, 1'b0, 1'b0, c_wb(1'b1, 1'b0),          "sll_wb");

        // R-type add
        drv(R_T, ADD, 1'b0, 1'b1, c_fetch(1'b1, 1'b0, 1'b0), "fetch_add");
        drv(R_T, ADD, 1'b0, 1'b0, c_decode(),                "decode_add");
        drv(R_T, ADD, 1'b0, 1'b0, c_exec_r(),                "exec_r");
        drv(R_T, ADD, 1'b0, 1'b0, c_wb(1'b1, 1'b0),          "add_wb");

        // addi
        drv(ADDI, ADD, 1'b0, 1'b1, c_fetch(1'b1, 1'b0, 1'b0), "fetch_addi");
        drv(ADDI, ADD, 1'b0, 1'b0, c_decode(),                "decode_addi");
        drv(ADDI, ADD, 1'b0, 1'b0, c_imm_alu(),               "exec_i");
        drv(ADDI, ADD, 1'b0, 1'b0, c_wb(1'b0, 1'b0),          "imm_wb");

        // lw with three wait cycles; ready arrives on the last budgeted cycle
        drv(LW, ADD, 1'b0, 1'b1, c_fetch(1'b1, 1'b0, 1'b0), "fetch_lw");
        drv(LW, ADD, 1'b0, 1'b0, c_decode(),                "decode_lw");
        drv(LW, ADD, 1'b0, 1'b0, c_imm_alu(),               "mem_addr_lw");
        for (int i = 0; i < 3; i++) drv(LW, ADD, 1'b0, 1'b0, c_mem(1'b0), "mem_rd_wait");
        drv(LW, ADD, 1'b0, 1'b1, c_mem(1'b0),               "mem_rd_ready");
        drv(LW, ADD, 1'b0, 1'b0, c_wb(1'b0, 1'b1),          "mem_wb");

        // beq taken and not taken
        for (int z = 1; z >= 0; z--) begin
            drv(BEQ, ADD, 1'(z), 1'b1, c_fetch(1'b1, 1'b0, 1'b0), "fetch_beq");
            drv(BEQ, ADD, 1'(z), 1'b0, c_decode(),                "decode_beq");
            drv(BEQ, ADD, 1'(z), 1'b0, c_branch(),                "branch");
        end

        // jump
        drv(JMP, ADD, 1'b0, 1'b1, c_fetch(1'b1, 1'b0, 1'b0), "fetch_j");
        drv(JMP, ADD, 1'b0, 1'b0, c_decode(),                "decode_j");
        drv(JMP, ADD, 1'b0, 1'b1, c_jump(),                  "jump");

        // illegal opcode
        drv(BAD, ADD, 1'b0, 1'b1, c_fetch(1'b1, 1'b0, 1'b0), "fetch_bad");
        drv(BAD, ADD, 1'b0, 1'b0, c_decode(),                "decode_bad");
        drv(SW,  ADD, 1'b0, 1'b0, c_fetch(1'b0, 1'b1, 1'b0), "illegal_pulse");

        // sw that times out after four waits
        drv(SW, ADD, 1'b0, 1'b1, c_fetch(1'b1, 1'b0, 1'b0), "fetch_sw");
        drv(SW, ADD, 1'b0, 1'b0, c_decode(),                "decode_sw");
        drv(SW, ADD, 1'b0, 1'b0, c_imm_alu(),               "mem_addr_sw");
        for (int i = 0; i < 4; i++) drv(SW, ADD, 1'b0, 1'b0, c_mem(1'b1), "mem_wr_wait");
        drv(LW, ADD, 1'b0, 1'b0, c_fetch(1'b0, 1'b0, 1'b1), "mem_err_pulse");

        // fetch stall also times out: mem_err_pulse cycle was wait 1
        for (int i = 0; i < 3; i++) drv(LW, ADD, 1'b0, 1'b0, c_fetch(1'b0, 1'b0, 1'b0), "fetch_stall");
        drv(LW, ADD, 1'b0, 1'b1, c_fetch(1'b1, 1'b0, 1'b1), "fetch_err_ready");

        // lw interrupted by reset while stalled in MEM_RD
        drv(LW, ADD, 1'b0, 1'b0, c_decode(),                "decode_lw2");
        drv(LW, ADD, 1'b0, 1'b0, c_imm_alu(),               "mem_addr_lw2");
        drv(LW, ADD, 1'b0, 1'b0, c_mem(1'b0),               "mem_rd_before_rst");
        #2;
        rst_n = 1'b0;
        push_exp(c_zero(), "rst_async");
        #1;
        chk();
        drv(LW, ADD, 1'b0, 1'b1, c_zero(), "rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(c_zero(), "idle_after_rst2");
        #1;
        chk();
        drv(LW, ADD, 1'b0, 1'b0, c_fetch(1'b0, 1'b0, 1'b0), "fetch_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
